// File: rtl/box_pixel_emitter_if.sv
// Plot request bus from the box pixel emitter to the VGA adapter write port.
// Latency: none, wiring only.
// Backpressure: slave holds plot_ready low to stall; head fields stay stable while plot && !plot_ready.
interface box_pixel_emitter_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic [X_W-1:0]      plot_x;
  logic [Y_W-1:0]      plot_y;
  logic [COLOUR_W-1:0] plot_colour;
  logic                plot;
  logic                plot_ready;

  modport master (
    output plot_x, plot_y, plot_colour, plot,
    input  plot_ready
  );

  modport slave (
    input  plot_x, plot_y, plot_colour, plot,
    output plot_ready
  );
endinterface

// File: rtl/box_pixel_emitter.sv
// Converts a box's linear pixel index stream to clipped screen (x,y) plot requests through a small FIFO.
// Latency: idx_valid in cycle N shows on plot/plot_x/plot_y in cycle N+1 when the FIFO was empty.
// Backpressure: the index stream cannot stall; pushes into a full FIFO are dropped and flagged in overflow.
module box_pixel_emitter #(
  parameter int IDX_W      = 17,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COLOUR_W   = 3,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [X_W-1:0]      box_x,
  input  logic [Y_W-1:0]      box_y,
  input  logic [X_W-1:0]      box_w,
  input  logic [COLOUR_W-1:0] box_colour,
  input  logic                idx_valid,
  input  logic [IDX_W-1:0]    idx,
  input  logic                idx_done,
  box_pixel_emitter_if.master pix,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                seq_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } entry_t;

  state_t state, state_nxt;

  // Box parameters captured on an accepted start.
  logic [X_W-1:0]      bx, bw;
  logic [Y_W-1:0]      by;
  logic [COLOUR_W-1:0] bc;

  // Position trackers; the pixel position comes from these, never from idx.
  logic [X_W-1:0]   col;
  logic [Y_W-1:0]   row;
  logic [IDX_W-1:0] exp_idx;

  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic [X_W:0] pix_x;
  logic [Y_W:0] pix_y;
  logic take, on_screen, push_req, fifo_empty, fifo_full, pop, push, drop, row_end;

  // One extra bit on each coordinate so origin + offset wrap-around lands off-screen.
  assign pix_x      = {1'b0, bx} + {1'b0, col};
  assign pix_y      = {1'b0, by} + {1'b0, row};
  assign on_screen  = (pix_x < (X_W+1)'(SCREEN_W)) && (pix_y < (Y_W+1)'(SCREEN_H));
  assign take       = (state == RUN) && idx_valid;
  assign push_req   = take && on_screen;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign pop        = !fifo_empty && pix.plot_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;
  assign row_end    = (({1'b0, col} + (X_W+1)'(1)) == {1'b0, bw});

  assign pix.plot        = !fifo_empty;
  assign pix.plot_x      = mem[rd_ptr].x;
  assign pix.plot_y      = mem[rd_ptr].y;
  assign pix.plot_colour = mem[rd_ptr].colour;

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and the done pulse; DRAIN holds until the last queued pixel has left.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx_done) state_nxt = DRAIN;
      DRAIN: begin
        if (fifo_empty) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Box latch, position trackers and sticky error flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bx       <= '0;
      by       <= '0;
      bw       <= '0;
      bc       <= '0;
      col      <= '0;
      row      <= '0;
      exp_idx  <= '0;
      overflow <= 1'b0;
      seq_err  <= 1'b0;
    end else if ((state == IDLE) && start) begin
      bx       <= box_x;
      by       <= box_y;
      bw       <= box_w;
      bc       <= box_colour;
      col      <= '0;
      row      <= '0;
      exp_idx  <= '0;
      overflow <= 1'b0;
      seq_err  <= 1'b0;
    end else if (take) begin
      if (idx != exp_idx) seq_err <= 1'b1;
      if (drop)           overflow <= 1'b1;
      exp_idx <= exp_idx + IDX_W'(1);
      if (row_end) begin
        col <= '0;
        row <= row + Y_W'(1);
      end else begin
        col <= col + X_W'(1);
      end
    end
  end

  // FIFO pointers and occupancy; reset empties the queue at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful under count, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{x: pix_x[X_W-1:0], y: pix_y[Y_W-1:0], colour: bc};
  end

endmodule

// File: tb/tb_box_pixel_emitter.sv
// Self-checking bench for box_pixel_emitter: table of boxes plus hand sequences for FIFO corner cases.
// Expected plot entries are queued as each index is driven and compared as the adapter side accepts them.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_box_pixel_emitter;

  localparam int IDX_W = 17;
  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int C_W   = 3;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [X_W-1:0]   box_x = '0;
  logic [Y_W-1:0]   box_y = '0;
  logic [X_W-1:0]   box_w = '0;
  logic [C_W-1:0]   box_colour = '0;
  logic             idx_valid = 1'b0;
  logic [IDX_W-1:0] idx = '0;
  logic             idx_done = 1'b0;
  logic             busy, done, overflow, seq_err;

  box_pixel_emitter_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(C_W)) pif ();

  box_pixel_emitter #(
    .IDX_W(IDX_W), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(C_W),
    .SCREEN_W(160), .SCREEN_H(120), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .box_x(box_x), .box_y(box_y), .box_w(box_w), .box_colour(box_colour),
    .idx_valid(idx_valid), .idx(idx), .idx_done(idx_done),
    .pix(pif),
    .busy(busy), .done(done), .overflow(overflow), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
  } pix_t;

  typedef struct {
    int bx, by, bw, c, n;
    bit done_sep;
    int emit;
    bit ovf, seq, lat;
  } vec_t;

  pix_t exp_q[$];
  vec_t vecs[5];
  int   n_cmp = 0, n_bad = 0, n_pop = 0, last_pop_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: position by division of the logical pixel number, clip on the full-range sum.
  task automatic model_push(input int bx, input int by, input int bw, input int c, input int i);
    int x, y;
    pix_t p;
    x = bx + (i % bw);
    y = by + (i / bw);
    if (x < 160 && y < 120) begin
      p.x = X_W'(x);
      p.y = Y_W'(y);
      p.c = C_W'(c);
      exp_q.push_back(p);
    end
  endtask

  task automatic monitor();
    pix_t e;
    forever begin
      @(negedge clk);
      if (resetn && pif.plot && pif.plot_ready) begin
        n_pop++;
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pop_x", int'(pif.plot_x), int'(e.x));
          check("pop_y", int'(pif.plot_y), int'(e.y));
          check("pop_colour", int'(pif.plot_colour), int'(e.c));
        end
      end
    end
  endtask

  task automatic do_start(input int bx, input int by, input int bw, input int c);
    @(posedge clk); #1;
    start = 1'b1;
    box_x = X_W'(bx);
    box_y = Y_W'(by);
    box_w = X_W'(bw);
    box_colour = C_W'(c);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_idx(input int v, input bit with_done);
    idx_valid = 1'b1;
    idx = IDX_W'(v);
    idx_done = with_done;
    @(posedge clk); #1;
    idx_valid = 1'b0;
    idx_done = 1'b0;
  endtask

  task automatic drive_done();
    idx_done = 1'b1;
    @(posedge clk); #1;
    idx_done = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit lat);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, int'(seen), 1);
    if (seen) begin
      if (lat) check({tag, "_done_latency"}, cyc - last_pop_cyc, 1);
      @(negedge clk);
      check({tag, "_done_pulse"}, int'(done), 0);
      check({tag, "_idle"}, int'(busy), 0);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int base;
    base = n_pop;
    pif.plot_ready = 1'b1;
    do_start(v.bx, v.by, v.bw, v.c);
    check({tag, "_busy"}, int'(busy), 1);
    for (int i = 0; i < v.n; i++) begin
      model_push(v.bx, v.by, v.bw, v.c, i);
      drive_idx(i, !v.done_sep && (i == v.n - 1));
    end
    if (v.done_sep) drive_done();
    wait_done(tag, v.lat);
    check({tag, "_overflow"}, int'(overflow), int'(v.ovf));
    check({tag, "_seq_err"}, int'(seq_err), int'(v.seq));
    check({tag, "_pops"}, n_pop - base, v.emit);
    check({tag, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int base;
    pif.plot_ready = 1'b0;
    //              bx   by  bw  c  n  sep emit ovf seq lat
    vecs[0] = '{ 10,  20,  3, 5,  6, 1'b1,  6, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{158, 119,  4, 2,  8, 1'b0,  2, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{ 30,  40,  5, 7, 10, 1'b0, 10, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{250,   0, 10, 1, 10, 1'b1,  0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{  0, 117,  1, 4,  5, 1'b0,  3, 1'b0, 1'b0, 1'b0};

    fork
      monitor();
    join_none

    #2;
    check("rst_plot", int'(pif.plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_seq_err", int'(seq_err), 0);
    #10 resetn = 1'b1;

    for (int t = 0; t < 5; t++) run_vec(vecs[t], $sformatf("vec%0d", t));

    // Stalled adapter: only DEPTH pixels fit, the rest are dropped.
    base = n_pop;
    pif.plot_ready = 1'b0;
    do_start(0, 0, 10, 1);
    for (int i = 0; i < 10; i++) begin
      if (i < DEPTH) model_push(0, 0, 10, 1, i);
      drive_idx(i, i == 9);
    end
    @(negedge clk);
    check("stall_plot", int'(pif.plot), 1);
    check("stall_head_x", int'(pif.plot_x), 0);
    check("stall_head_y", int'(pif.plot_y), 0);
    check("stall_overflow", int'(overflow), 1);
    @(posedge clk); #1;
    pif.plot_ready = 1'b1;
    wait_done("stall", 1'b1);
    check("stall_pops", n_pop - base, DEPTH);
    check("stall_overflow_sticky", int'(overflow), 1);
    check("stall_left", exp_q.size(), 0);

    // Index discontinuity: position follows the internal tracker.
    base = n_pop;
    pif.plot_ready = 1'b1;
    do_start(0, 0, 2, 3);
    model_push(0, 0, 2, 3, 0);
    drive_idx(0, 1'b0);
    model_push(0, 0, 2, 3, 1);
    drive_idx(1, 1'b0);
    @(negedge clk);
    check("seq_before", int'(seq_err), 0);
    model_push(0, 0, 2, 3, 2);
    drive_idx(3, 1'b1);
    @(negedge clk);
    check("seq_after", int'(seq_err), 1);
    wait_done("seq", 1'b1);
    check("seq_pops", n_pop - base, 3);
    check("seq_overflow", int'(overflow), 0);

    // Reset mid-run with three queued entries.
    pif.plot_ready = 1'b0;
    do_start(0, 0, 8, 4);
    for (int i = 0; i < 3; i++) drive_idx(i, 1'b0);
    @(negedge clk);
    check("prerst_plot", int'(pif.plot), 1);
    resetn = 1'b0;
    #1;
    check("midrst_plot", int'(pif.plot), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_seq_err", int'(seq_err), 0);
    #20 resetn = 1'b1;
    run_vec(vecs[0], "post_reset");

    // Full FIFO with a pop and a push in the same cycle.
    base = n_pop;
    pif.plot_ready = 1'b0;
    do_start(0, 0, 10, 6);
    for (int i = 0; i < DEPTH; i++) begin
      model_push(0, 0, 10, 6, i);
      drive_idx(i, 1'b0);
    end
    pif.plot_ready = 1'b1;
    model_push(0, 0, 10, 6, DEPTH);
    drive_idx(DEPTH, 1'b0);
    pif.plot_ready = 1'b0;
    @(negedge clk);
    check("swap_head_x", int'(pif.plot_x), 1);
    check("swap_overflow", int'(overflow), 0);
    drive_idx(DEPTH + 1, 1'b0);
    @(negedge clk);
    check("swap_still_full", int'(overflow), 1);
    @(posedge clk); #1;
    pif.plot_ready = 1'b1;
    drive_done();
    wait_done("swap", 1'b1);
    check("swap_pops", n_pop - base, DEPTH + 1);
    check("swap_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
